// File: rtl/pixel_filter_pipe_if.sv
// Stream bundle between the window generator (master) and the pixel filter (slave).
// Carries the chunk input handshake and the filtered-pixel output handshake.
interface pixel_filter_pipe_if #(
    parameter int CH_W = 8,
    parameter int NCH  = 3
);
    logic                      in_valid;
    logic                      in_ready;
    logic [1:0]                in_mode;
    logic [9*NCH*CH_W-1:0]     in_chunk;
    logic                      out_valid;
    logic                      out_ready;
    logic [NCH*CH_W-1:0]       out_pixel;

    modport master (
        output in_valid, in_mode, in_chunk, out_ready,
        input  in_ready, out_valid, out_pixel
    );

    modport slave (
        input  in_valid, in_mode, in_chunk, out_ready,
        output in_ready, out_valid, out_pixel
    );
endinterface

// File: rtl/pixel_filter_pipe.sv
// Four-stage streaming 3x3 filter: bypass, threshold or median per beat, per channel.
// Valid/ready pipeline with per-stage valid bits so bubbles collapse under backpressure.
module pixel_filter_pipe #(
    parameter int CH_W   = 8,
    parameter int NCH    = 3,
    parameter int THRESH = (2**CH_W - 1) / 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pixel_filter_pipe_if.slave bus
);
    typedef logic [CH_W-1:0] ch_t;

    localparam ch_t THR = ch_t'(THRESH);

    function automatic ch_t min2(input ch_t x, input ch_t y);
        return (x < y) ? x : y;
    endfunction

    function automatic ch_t max2(input ch_t x, input ch_t y);
        return (x < y) ? y : x;
    endfunction

    function automatic ch_t med3(input ch_t x, input ch_t y, input ch_t z);
        return max2(min2(x, y), min2(max2(x, y), z));
    endfunction

    function automatic ch_t px(input logic [9*NCH*CH_W-1:0] c, input int p, input int ch);
        return c[(p*NCH + ch)*CH_W +: CH_W];
    endfunction

    logic vld_p1_q, vld_p2_q, vld_p3_q, vld_p4_q;
    logic vld_p1_d, vld_p2_d, vld_p3_d, vld_p4_d;
    logic en1, en2, en3, en4;

    ch_t  lo_p1_q [NCH][3], mid_p1_q [NCH][3], hi_p1_q [NCH][3], res_p1_q [NCH];
    ch_t  lo_p1_d [NCH][3], mid_p1_d [NCH][3], hi_p1_d [NCH][3], res_p1_d [NCH];
    logic med_p1_q, med_p1_d;

    ch_t  a_p2_q [NCH], b_p2_q [NCH], c_p2_q [NCH], res_p2_q [NCH];
    ch_t  a_p2_d [NCH], b_p2_d [NCH], c_p2_d [NCH], res_p2_d [NCH];
    logic med_p2_q, med_p2_d;

    ch_t  res_p3_q [NCH], res_p3_d [NCH];

    logic [NCH*CH_W-1:0] pix_p4_q, pix_p4_d;

    // A stage may load when it is empty or its contents are moving on this cycle.
    assign en4 = !vld_p4_q || bus.out_ready;
    assign en3 = !vld_p3_q || en4;
    assign en2 = !vld_p2_q || en3;
    assign en1 = !vld_p1_q || en2;

    assign bus.in_ready  = en1;
    assign bus.out_valid = vld_p4_q;
    assign bus.out_pixel = pix_p4_q;

    always_comb begin
        vld_p1_d = en1 ? bus.in_valid : vld_p1_q;
        vld_p2_d = en2 ? vld_p1_q     : vld_p2_q;
        vld_p3_d = en3 ? vld_p2_q     : vld_p3_q;
        vld_p4_d = en4 ? vld_p3_q     : vld_p4_q;
    end

    // S1: row sorts for the median, threshold/bypass result from the centre pixel
    always_comb begin
        lo_p1_d  = '{default: '{default: '0}};
        mid_p1_d = '{default: '{default: '0}};
        hi_p1_d  = '{default: '{default: '0}};
        res_p1_d = '{default: '0};
        med_p1_d = (bus.in_mode == 2'd2);
        for (int ch = 0; ch < NCH; ch++) begin
            for (int r = 0; r < 3; r++) begin
                lo_p1_d[ch][r]  = min2(min2(px(bus.in_chunk, 3*r, ch), px(bus.in_chunk, 3*r+1, ch)),
                                       px(bus.in_chunk, 3*r+2, ch));
                mid_p1_d[ch][r] = med3(px(bus.in_chunk, 3*r, ch), px(bus.in_chunk, 3*r+1, ch),
                                       px(bus.in_chunk, 3*r+2, ch));
                hi_p1_d[ch][r]  = max2(max2(px(bus.in_chunk, 3*r, ch), px(bus.in_chunk, 3*r+1, ch)),
                                       px(bus.in_chunk, 3*r+2, ch));
            end
            if (bus.in_mode == 2'd1)
                res_p1_d[ch] = (px(bus.in_chunk, 4, ch) > THR) ? '1 : '0;
            else
                res_p1_d[ch] = px(bus.in_chunk, 4, ch);
        end
    end

    // S2: the true median lies in the set {max of lows, median of mids, min of highs}
    always_comb begin
        a_p2_d   = '{default: '0};
        b_p2_d   = '{default: '0};
        c_p2_d   = '{default: '0};
        res_p2_d = res_p1_q;
        med_p2_d = med_p1_q;
        for (int ch = 0; ch < NCH; ch++) begin
            a_p2_d[ch] = max2(max2(lo_p1_q[ch][0], lo_p1_q[ch][1]), lo_p1_q[ch][2]);
            b_p2_d[ch] = med3(mid_p1_q[ch][0], mid_p1_q[ch][1], mid_p1_q[ch][2]);
            c_p2_d[ch] = min2(min2(hi_p1_q[ch][0], hi_p1_q[ch][1]), hi_p1_q[ch][2]);
        end
    end

    // S3: final median select, S4 packs the output word
    always_comb begin
        res_p3_d = '{default: '0};
        pix_p4_d = '0;
        for (int ch = 0; ch < NCH; ch++) begin
            res_p3_d[ch] = med_p2_q ? med3(a_p2_q[ch], b_p2_q[ch], c_p2_q[ch]) : res_p2_q[ch];
            pix_p4_d[ch*CH_W +: CH_W] = res_p3_q[ch];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            vld_p3_q <= 1'b0;
            vld_p4_q <= 1'b0;
            pix_p4_q <= '0;
        end else begin
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            vld_p3_q <= vld_p3_d;
            vld_p4_q <= vld_p4_d;
            if (en4) pix_p4_q <= pix_p4_d;
        end
    end

    always_ff @(posedge clk) begin
        if (en1) begin
            lo_p1_q  <= lo_p1_d;
            mid_p1_q <= mid_p1_d;
            hi_p1_q  <= hi_p1_d;
            res_p1_q <= res_p1_d;
            med_p1_q <= med_p1_d;
        end
        if (en2) begin
            a_p2_q   <= a_p2_d;
            b_p2_q   <= b_p2_d;
            c_p2_q   <= c_p2_d;
            res_p2_q <= res_p2_d;
            med_p2_q <= med_p2_d;
        end
        if (en3) res_p3_q <= res_p3_d;
    end
endmodule

// File: tb/tb_pixel_filter_pipe.sv
// Scoreboard bench for pixel_filter_pipe: driver pushes expected pixels, monitor pops on output.
// Reference model sorts the 9 neighbourhood values directly.
module tb_pixel_filter_pipe;
  localparam int CH_W   = 8;
  localparam int NCH    = 3;
  localparam int THRESH = (2**CH_W - 1) / 2;
  localparam int CMAX   = 2**CH_W - 1;

  typedef logic [9*NCH*CH_W-1:0] chunk_t;
  typedef logic [NCH*CH_W-1:0]   pix_t;
  typedef struct {
    pix_t pix;
    int   acc;
    bit   lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_chk = 0;
  int   n_fail = 0;
  int   acc_cnt = 0;
  bit   lat_en = 1'b0;
  exp_t sbq[$];
  bit   stall_prev = 1'b0;
  pix_t prev_pix;
  int   last_pop = -10;
  int   prev_pop = -10;

  int rv[9] = '{9, 1, 8, 2, 7, 3, 6, 4, 5};
  int bv[9] = '{0, 0, 0, 0, 255, 255, 255, 255, 255};
  int edge_vals[4] = '{0, 127, 128, 255};

  pixel_filter_pipe_if #(.CH_W(CH_W), .NCH(NCH)) bus ();
  pixel_filter_pipe #(.CH_W(CH_W), .NCH(NCH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  pixel_filter_pipe_if #(.CH_W(4), .NCH(1)) bus4 ();
  pixel_filter_pipe #(.CH_W(4), .NCH(1)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  function automatic pix_t model(input chunk_t c, input logic [1:0] m);
    pix_t r;
    int   q[$];
    int   centre;
    r = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      centre = int'(c[(4*NCH + ch)*CH_W +: CH_W]);
      if (m == 2'd1) begin
        r[ch*CH_W +: CH_W] = (centre > THRESH) ? CH_W'(CMAX) : '0;
      end else if (m == 2'd2) begin
        q.delete();
        for (int p = 0; p < 9; p++) q.push_back(int'(c[(p*NCH + ch)*CH_W +: CH_W]));
        q.sort();
        r[ch*CH_W +: CH_W] = CH_W'(q[4]);
      end else begin
        r[ch*CH_W +: CH_W] = CH_W'(centre);
      end
    end
    return r;
  endfunction

  function automatic chunk_t rand_chunk();
    chunk_t c;
    for (int i = 0; i < 9*NCH; i++)
      c[i*CH_W +: CH_W] = ($urandom_range(0, 3) == 0) ? CH_W'(edge_vals[$urandom_range(0, 3)])
                                                      : CH_W'($urandom);
    return c;
  endfunction

  // Monitor: pops the scoreboard on every output transfer, watches hold-during-stall
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check("hold_valid", bus.out_valid, 1'b1);
        check("hold_pixel", bus.out_pixel, prev_pix);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (sbq.size() == 0) begin
          check("unexpected_output", bus.out_pixel, 64'hDEAD);
        end else begin
          e = sbq.pop_front();
          check("out_pixel", bus.out_pixel, e.pix);
          if (e.lat) check("latency", cyc - e.acc, 4);
        end
        prev_pop = last_pop;
        last_pop = cyc;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_pix   = bus.out_pixel;
    end
  end

  task automatic send(input logic [1:0] m, input chunk_t c, input pix_t e);
    int w;
    bit done;
    exp_t x;
    w = 0;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_chunk = c;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready) begin
        x.pix = e;
        x.acc = cyc;
        x.lat = lat_en;
        sbq.push_back(x);
        acc_cnt++;
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        w++;
        if (w > 100) begin
          check("send_timeout", 1, 0);
          done = 1'b1;
        end
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_rand(input logic [1:0] m);
    chunk_t c;
    c = rand_chunk();
    send(m, c, model(c, m));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() != 0 && w < 300) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_empty", sbq.size(), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    chunk_t c;
    int w;
    int acc0;

    bus.in_valid = 1'b0;  bus.in_mode = 2'd0;  bus.in_chunk = '0;  bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_mode = 2'd0; bus4.in_chunk = '0; bus4.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_pixel", bus.out_pixel, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_after_rst", bus.in_ready, 1);

    // CH_W=4 threshold boundary: 7 -> 0, 8 -> 15
    bus4.in_valid = 1'b1; bus4.in_mode = 2'd1; bus4.in_chunk = 36'd7 << 16;
    @(posedge clk); #1;
    bus4.in_chunk = 36'd8 << 16;
    @(posedge clk); #1;
    bus4.in_valid = 1'b0;
    w = 0;
    @(negedge clk);
    while (!bus4.out_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    check("t4_valid0", bus4.out_valid, 1);
    check("t4_centre7", bus4.out_pixel, 4'd0);
    @(negedge clk);
    check("t4_valid1", bus4.out_valid, 1);
    check("t4_centre8", bus4.out_pixel, 4'd15);
    @(posedge clk); #1;

    bus.out_ready = 1'b1;
    lat_en = 1'b1;

    // Directed median from the worked example
    c = '0;
    for (int p = 0; p < 9; p++) begin
      c[(p*NCH + 0)*CH_W +: CH_W] = CH_W'(rv[p]);
      c[(p*NCH + 1)*CH_W +: CH_W] = CH_W'(200);
      c[(p*NCH + 2)*CH_W +: CH_W] = CH_W'(bv[p]);
    end
    send(2'd2, c, {8'd255, 8'd200, 8'd5});

    // Directed threshold at the cut level
    c = rand_chunk();
    c[(4*NCH + 0)*CH_W +: CH_W] = 8'd127;
    c[(4*NCH + 1)*CH_W +: CH_W] = 8'd128;
    c[(4*NCH + 2)*CH_W +: CH_W] = 8'd255;
    send(2'd1, c, {8'd255, 8'd255, 8'd0});

    // Bypass and mode 3 on the same chunk must both return the centre
    for (int i = 0; i < 4; i++) begin
      c = rand_chunk();
      send(2'd0, c, c[4*NCH*CH_W +: NCH*CH_W]);
      send(2'd3, c, c[4*NCH*CH_W +: NCH*CH_W]);
    end

    // Random modes, no backpressure, random input gaps
    for (int i = 0; i < 30; i++) begin
      send_rand(2'($urandom_range(0, 3)));
      idle($urandom_range(0, 2));
    end
    drain();

    // Backpressure: 6 stalled cycles while streaming 10 mixed beats
    lat_en = 1'b0;
    acc0 = acc_cnt;
    fork
      begin
        bus.out_ready = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        check("bp_accepted", acc_cnt - acc0, 4);
        check("bp_in_ready_low", bus.in_ready, 0);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 10; i++) send_rand(2'(i % 4));
      end
    join
    drain();
    check("bp_total", acc_cnt - acc0, 10);

    // Bubble collapse with output stalled
    bus.out_ready = 1'b0;
    acc0 = acc_cnt;
    send_rand(2'd2);
    repeat (3) begin
      @(negedge clk);
      check("bubble_in_ready", bus.in_ready, 1);
      @(posedge clk);
      #1;
    end
    send_rand(2'd1);
    check("bubble_accepted", acc_cnt - acc0, 2);
    idle(4);
    bus.out_ready = 1'b1;
    drain();
    check("bubble_back_to_back", last_pop - prev_pop, 1);

    // Reset with three beats in flight
    lat_en = 1'b1;
    for (int i = 0; i < 3; i++) send_rand(2'($urandom_range(0, 3)));
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_pixel", bus.out_pixel, 0);
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    send_rand(2'd2);
    idle(8);
    drain();

    // Random modes under random backpressure
    lat_en = 1'b0;
    fork
      begin
        repeat (150) begin
          @(posedge clk);
          #1;
          bus.out_ready = 1'($urandom_range(0, 1));
        end
        bus.out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 40; i++) begin
          send_rand(2'($urandom_range(0, 3)));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_filter_pipe.md
Name: pixel_filter_pipe

Overview:
- Streaming per-channel pixel filter with a parametrised channel width and channel count.
- Each input beat is one 3x3 neighbourhood (chunk). Each output beat is one filtered centre pixel.
- Selectable per beat: bypass, on/off threshold (with configurable cut level), or 3x3 median.
- Sits between the line-buffer/window generator and the pixel sink.
- Uses a 4-stage valid/ready pipeline with bubble collapsing.

Parameters:
- CH_W, 8, bits per colour channel.
- NCH, 3, channels per pixel; ch0=red, ch1=grn, ch2=blu.
- THRESH, (2**CH_W-1)/2, cut level for threshold mode (127 at default CH_W).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  chunk and mode present.
- in_ready  out  1  pipeline can accept this cycle.
- in_mode  in  2  per-beat mode: 0 bypass, 1 threshold, 2 median, 3 treated as bypass.
- in_chunk  in  9*NCH*CH_W  pixel p = r*3+c (row-major, p=4 is centre); channel ch at bits [(p*NCH+ch)*CH_W +: CH_W].
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts.
- out_pixel  out  NCH*CH_W  filtered pixel; channel ch at [ch*CH_W +: CH_W].

Behaviour:
- Reset (async assert, sync release): all stage valid bits cleared; out_valid=0, out_pixel=0. in_ready=1 from the first cycle after release. Reset mid-operation drops every in-flight beat; no partial output appears.
- Handshake:
  - Transfer on valid&&ready.
  - in_valid/in_chunk/in_mode must hold until accepted.
  - out_valid/out_pixel hold stable while out_valid&&!out_ready.
- Pipeline: stages S1..S4, each with its own valid bit. Stage k loads when it is empty or stage k+1 is loading (or, for S4, out_ready=1). in_ready = S1 empty or S1 advancing. Bubbles collapse, so a stalled output lets upstream stages fill.
- Latency: exactly 4 cycles from acceptance to out_valid with no backpressure. Throughput is 1 beat/cycle. Mode travels with the data through every stage, so mixed modes in flight are legal and outputs stay in order.
- Median datapath, per channel independently:
  - S1: sort each row of 3 into lo/mid/hi.
  - S2: a=max(lo0,lo1,lo2), b=median(mid0,mid1,mid2), c=min(hi0,hi1,hi2).
  - S3: m=median(a,b,c).
  - S4: output register.
  - All compares are unsigned; ties allowed with any stable ordering, and the result is still the exact median.
- Threshold: channel out = (centre channel > THRESH) ? 2**CH_W-1 : 0. The compare is strictly greater. Computed in S1, carried through S2-S3.
- Bypass / mode 3: centre pixel (p=4) unchanged.
- No arithmetic widening; all values stay CH_W bits.
- Simultaneous accept at in and drain at out in the same cycle keeps a full pipeline full, with in_ready=1.

Test Plan:
- Median, red channel: chunk {9,1,8,2,7,3,6,4,5}, grn all 200, blu {0,0,0,0,255,255,255,255,255}, mode 2. Expect out_pixel red=5, grn=200, blu=255, 4 cycles after accept.
- Threshold, mode 1, CH_W=8: centre red=127, grn=128, blu=255. Expect {0,255,255}. Also a CH_W=4 build with centre 7 vs 8 → 0 / 15.
- Bypass/mode 3: random chunks. Expect out_pixel = in_chunk centre pixel exactly; mode 3 output is identical to mode 0.
- Backpressure: stream 10 beats of mixed modes with out_ready held low for 6 cycles. Expect:
  - in_ready falls after 4 beats are accepted.
  - out_pixel is held stable during the stall.
  - All 10 results arrive in order with none lost or duplicated.
- Bubble collapse: send a beat, 3 idle cycles, a beat, with out_ready=0. Expect both beats buffered (in_ready stays 1) and delivered back-to-back once out_ready=1.
- Reset mid-stream: assert rst_n=0 with 3 beats in flight. Expect out_valid=0 immediately, no stale outputs after release, and the first new beat output 4 cycles after accept.
